axil_arbiter_wr: RTL and testbench

- Write-channel arbiter for the AXI-Lite interconnect; produces the per-slave master grant vectors consumed by the write crossbar.
- Decodes each master's awaddr to a target slave and runs one round-robin arbiter per slave.
- Holds each grant across the AW, W and B phases of one transaction, then releases it.
- Guarantees at most one grant bit per slave and at most one granted slave per master.

---
 rtl/axil_pkg.sv | 15 +
 rtl/axil_rr_arbiter.sv | 42 ++++
 rtl/axil_arbiter_wr.sv | 118 +++++++++++
 tb/tb_axil_arbiter_wr.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI-Lite write-channel arbiter.
package axil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } axil_arb_state_t;

  // Index width for n items; a single item still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Round-robin picker for one slave: first requester at or after the pointer,
// with wrap-around. The pointer moves past the winner only when enabled.
module axil_rr_arbiter
  import axil_pkg::*;
#(
  parameter int NUMBER_MASTER = 2,
  localparam int RW = idx_w(NUMBER_MASTER)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUMBER_MASTER-1:0] req,
  input  logic                     en,
  output logic [NUMBER_MASTER-1:0] grant,
  output logic [RW-1:0]            rr
);

  logic          found;
  logic [RW-1:0] rr_nxt;
  int            idx;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    rr_nxt = rr;
    idx    = 0;
    for (int k = 0; k < NUMBER_MASTER; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUMBER_MASTER) idx = idx - NUMBER_MASTER;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        rr_nxt     = (idx + 1 == NUMBER_MASTER) ? '0 : RW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             rr <= '0;
    else if (en && found) rr <= rr_nxt;
  end

endmodule

// File: rtl/axil_arbiter_wr.sv
// Write-channel arbiter: decodes awaddr per master, one round-robin arbiter and
// grant-holding FSM per slave. A grant lives from AW request through B handshake.
module axil_arbiter_wr
  import axil_pkg::*;
#(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic [NUMBER_MASTER-1:0][AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  input  logic [NUMBER_MASTER-1:0]                     m_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]                      s_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]                      s_axil_awready,
  input  logic [NUMBER_SLAVE-1:0]                      s_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]                      s_axil_wready,
  input  logic [NUMBER_SLAVE-1:0]                      s_axil_bvalid,
  input  logic [NUMBER_SLAVE-1:0]                      s_axil_bready,
  output logic [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0]   grant_wr
);

  localparam int SW = idx_w(NUMBER_SLAVE);
  localparam int RW = idx_w(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0]                   busy;
  logic [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0] req;

  // A master holding any grant may not win a second slave until it is released.
  always_comb begin
    busy = '0;
    for (int s = 0; s < NUMBER_SLAVE; s++)
      for (int m = 0; m < NUMBER_MASTER; m++)
        busy[m] = busy[m] | grant_wr[s][m];
  end

  always_comb begin
    req = '0;
    for (int s = 0; s < NUMBER_SLAVE; s++)
      for (int m = 0; m < NUMBER_MASTER; m++)
        req[s][m] = m_axil_awvalid[m] && !busy[m] &&
                    (m_axil_awaddr[m][AXI_ADDR_WIDTH-1 -: SW] == SW'(s));
  end

  for (genvar s = 0; s < NUMBER_SLAVE; s++) begin : g_slave
    axil_arb_state_t          state, state_nxt;
    logic                     aw_done, w_done, aw_nxt, w_nxt;
    logic                     aw_hs, w_hs, b_hs;
    logic [NUMBER_MASTER-1:0] gnt_q, gnt_nxt, arb_gnt;
    logic [RW-1:0]            rr;
    logic                     arb_en;

    assign aw_hs  = s_axil_awvalid[s] & s_axil_awready[s];
    assign w_hs   = s_axil_wvalid[s]  & s_axil_wready[s];
    assign b_hs   = s_axil_bvalid[s]  & s_axil_bready[s];
    assign arb_en = (state == ST_IDLE);

    axil_rr_arbiter #(.NUMBER_MASTER(NUMBER_MASTER)) u_rr (
      .clk   (aclk),
      .rst   (areset),
      .req   (req[s]),
      .en    (arb_en),
      .grant (arb_gnt),
      .rr    (rr)
    );

    always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      aw_nxt    = aw_done;
      w_nxt     = w_done;
      case (state)
        ST_IDLE: begin
          gnt_nxt = '0;
          if (|req[s]) begin
            gnt_nxt   = arb_gnt;
            aw_nxt    = 1'b0;
            w_nxt     = 1'b0;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          // AW and W may complete in either order or together; B here is ignored.
          aw_nxt = aw_done | aw_hs;
          w_nxt  = w_done  | w_hs;
          if (aw_nxt && w_nxt) state_nxt = ST_RESP;
        end
        ST_RESP: begin
          if (b_hs) begin
            gnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          gnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge aclk) begin
      if (areset) begin
        state   <= ST_IDLE;
        gnt_q   <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        state   <= state_nxt;
        gnt_q   <= gnt_nxt;
        aw_done <= aw_nxt;
        w_done  <= w_nxt;
      end
    end

    assign grant_wr[s] = gnt_q;
  end

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Bench for axil_arbiter_wr: directed per-cycle vector table, then random traffic
// checked against a transaction-level ownership model.
module tb_axil_arbiter_wr;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AW = 8;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic [NM-1:0][AW-1:0] awaddr;
  logic [NM-1:0]         awvalid;
  logic [NS-1:0]         s_awv, s_awr, s_wv, s_wr, s_bv, s_br;
  logic [NS-1:0][NM-1:0] grant_wr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  axil_arbiter_wr #(.NUMBER_MASTER(NM), .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .m_axil_awaddr  (awaddr),
    .m_axil_awvalid (awvalid),
    .s_axil_awvalid (s_awv),
    .s_axil_awready (s_awr),
    .s_axil_wvalid  (s_wv),
    .s_axil_wready  (s_wr),
    .s_axil_bvalid  (s_bv),
    .s_axil_bready  (s_br),
    .grant_wr       (grant_wr)
  );

  // Reference: who owns each slave, which phases have been seen, and the rr pointer.
  int owner [NS];
  bit got_aw[NS];
  bit got_w [NS];
  int ptr   [NS];

  function automatic logic [NS*NM-1:0] model_grants();
    logic [NS*NM-1:0] g = '0;
    for (int s = 0; s < NS; s++)
      if (owner[s] >= 0) g[s*NM + owner[s]] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    bit busy[NM];
    if (areset) begin
      for (int s = 0; s < NS; s++) begin
        owner[s] = -1; got_aw[s] = 0; got_w[s] = 0; ptr[s] = 0;
      end
      return;
    end
    for (int m = 0; m < NM; m++) begin
      busy[m] = 0;
      for (int s = 0; s < NS; s++) if (owner[s] == m) busy[m] = 1;
    end
    for (int s = 0; s < NS; s++) begin
      if (owner[s] < 0) begin
        for (int k = 0; k < NM; k++) begin
          int m = (ptr[s] + k) % NM;
          int tgt = int'(awaddr[m]) / (256 / NS);
          if (owner[s] < 0 && awvalid[m] && !busy[m] && tgt == s) begin
            owner[s] = m; got_aw[s] = 0; got_w[s] = 0; ptr[s] = (m + 1) % NM;
          end
        end
      end else if (!(got_aw[s] && got_w[s])) begin
        if (s_awv[s] && s_awr[s]) got_aw[s] = 1;
        if (s_wv[s] && s_wr[s])   got_w[s]  = 1;
      end else if (s_bv[s] && s_br[s]) begin
        owner[s] = -1;
      end
    end
  endtask

  // One clock: DUT and model both consume the currently driven inputs.
  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [NS*NM-1:0] exp);
    n_checks++;
    if (grant_wr === exp) n_pass++;
    else $display("FAIL %s: grant_wr=%h expected %h", name, grant_wr, exp);
  endtask

  typedef struct {
    bit            rst;
    logic [NM-1:0] awv;
    logic [AW-1:0] a0, a1;
    logic [NS-1:0] aw, w, bv, br;
    logic [7:0]    exp;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(bit rst, logic [1:0] awv, logic [7:0] a0, logic [7:0] a1,
                              logic [3:0] aw, logic [3:0] w, logic [3:0] bv,
                              logic [3:0] br, logic [7:0] exp);
    row_t r;
    r.rst = rst; r.awv = awv; r.a0 = a0; r.a1 = a1;
    r.aw = aw; r.w = w; r.bv = bv; r.br = br; r.exp = exp;
    return r;
  endfunction

  initial begin
    areset = 1'b1; awvalid = '0; awaddr = '0;
    s_awv = '0; s_awr = '0; s_wv = '0; s_wr = '0; s_bv = '0; s_br = '0;

    //                rst awv  a0     a1     aw  w   bv  br  exp
    tbl.push_back(mk(1, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00)); // reset
    tbl.push_back(mk(0, 2'd1, 8'h80, 8'h00, 0, 0, 0, 0, 8'h10)); // single write
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 4, 0, 0, 0, 8'h10));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 4, 0, 0, 8'h10));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 4, 4, 8'h00));
    tbl.push_back(mk(0, 2'd3, 8'h40, 8'h40, 0, 0, 0, 0, 8'h04)); // contention
    tbl.push_back(mk(0, 2'd2, 8'h40, 8'h40, 2, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 2'd2, 8'h40, 8'h40, 0, 2, 0, 0, 8'h04));
    tbl.push_back(mk(0, 2'd2, 8'h40, 8'h40, 0, 0, 2, 2, 8'h00)); // mandatory gap
    tbl.push_back(mk(0, 2'd2, 8'h40, 8'h40, 0, 0, 0, 0, 8'h08));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 2, 2, 0, 0, 8'h08));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2, 2, 8'h00));
    tbl.push_back(mk(0, 2'd3, 8'h40, 8'h40, 0, 0, 0, 0, 8'h04)); // rr back to m0
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 2, 2, 0, 0, 8'h04));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2, 2, 8'h00));
    tbl.push_back(mk(0, 2'd3, 8'h00, 8'hC0, 0, 0, 0, 0, 8'h81)); // parallel
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h81));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 8, 0, 1, 1, 8'h80));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 8, 0, 0, 8'h80));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 8, 8, 8'h00));
    tbl.push_back(mk(0, 2'd1, 8'h80, 8'h00, 0, 0, 0, 0, 8'h10)); // W before AW
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 4, 0, 0, 8'h10));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 4, 4, 8'h10)); // B in DATA ignored
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 4, 0, 0, 0, 8'h10));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 4, 0, 8'h10)); // bready low
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 4, 4, 8'h00));
    tbl.push_back(mk(0, 2'd1, 8'h80, 8'h00, 0, 0, 0, 0, 8'h10)); // busy mask
    tbl.push_back(mk(0, 2'd1, 8'h00, 8'h00, 4, 4, 0, 0, 8'h10));
    tbl.push_back(mk(0, 2'd1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h10));
    tbl.push_back(mk(0, 2'd1, 8'h00, 8'h00, 0, 0, 4, 4, 8'h00));
    tbl.push_back(mk(0, 2'd1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h01));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h01));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h00));
    tbl.push_back(mk(0, 2'd3, 8'h40, 8'h80, 0, 0, 0, 0, 8'h24)); // reset mid-RESP
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 6, 6, 0, 0, 8'h24));
    tbl.push_back(mk(1, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 2'd3, 8'h40, 8'h40, 0, 0, 0, 0, 8'h04)); // rr[1] back to 0
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 2, 2, 0, 0, 8'h04));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2, 2, 8'h00));
    tbl.push_back(mk(0, 2'd2, 8'h00, 8'hC0, 0, 0, 0, 0, 8'h80));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 8, 8, 0, 0, 8'h80));
    tbl.push_back(mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 8, 8, 8'h00));

    foreach (tbl[i]) begin
      areset    = tbl[i].rst;
      awvalid   = tbl[i].awv;
      awaddr[0] = tbl[i].a0;
      awaddr[1] = tbl[i].a1;
      s_awv = tbl[i].aw; s_awr = tbl[i].aw;
      s_wv  = tbl[i].w;  s_wr  = tbl[i].w;
      s_bv  = tbl[i].bv; s_br  = tbl[i].br;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Random traffic; handshakes are independent per slave and per phase.
    for (int c = 0; c < 3000; c++) begin
      areset  = ($urandom_range(0, 199) == 0);
      awvalid = NM'($urandom);
      for (int m = 0; m < NM; m++) awaddr[m] = AW'($urandom);
      s_awv = NS'($urandom); s_awr = NS'($urandom);
      s_wv  = NS'($urandom); s_wr  = NS'($urandom);
      s_bv  = NS'($urandom); s_br  = NS'($urandom);
      tick();
      check($sformatf("rand%0d", c), model_grants());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
